// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Purpose  : Instruction-memory responder for the fetch interface. Accepts
//             word-aligned fetch addresses over a valid/ready request channel,
//             reads a synchronous word-addressed store and returns instruction,
//             address and fault status through a small response FIFO.
//             A load port fills the store; a flush input drops all in-flight
//             and buffered fetches on a redirect.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RESP_DEPTH  = 4,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    // fetch request channel
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [31:0] io_req_addr,
    // fetch response channel
    output logic        io_resp_valid,
    input  logic        io_resp_ready,
    output logic [31:0] io_resp_inst,
    output logic [31:0] io_resp_addr,
    output logic [1:0]  io_resp_fault,
    // redirect
    input  logic        io_flush,
    // program-load port
    input  logic        io_wr_en,
    input  logic [31:0] io_wr_addr,
    input  logic [31:0] io_wr_data
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [31:0]      c_depth_words = DEPTH_WORDS;
    localparam logic [CNT_W:0]   c_resp_depth  = RESP_DEPTH[CNT_W:0];
    localparam logic [PTR_W-1:0] c_ptr_one     = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_one     = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_fault_ok    = 2'd0;
    localparam logic [1:0] c_fault_misal = 2'd1;
    localparam logic [1:0] c_fault_range = 2'd2;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];

    // Stage s1: registered read data plus the request's address and fault.
    logic        r_s1_valid;
    logic [31:0] r_s1_rdata;
    logic [31:0] r_s1_addr;
    logic [1:0]  r_s1_fault;

    // Response FIFO.
    logic [31:0]      r_fifo_inst  [RESP_DEPTH];
    logic [31:0]      r_fifo_addr  [RESP_DEPTH];
    logic [1:0]       r_fifo_fault [RESP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [31:0]       w_req_word;
    logic [1:0]        w_req_fault;
    logic [ADDR_W-1:0] w_req_idx;
    logic [31:0]       w_wr_word;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_wr_in_range;
    logic [CNT_W:0]    w_occupancy;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_resp_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic [31:0]       w_push_inst;
    logic              w_unused_wr_lsb;

    assign w_req_word = {2'b00, io_req_addr[31:2]};
    assign w_req_idx  = io_req_addr[ADDR_W+1:2];
    assign w_wr_word  = {2'b00, io_wr_addr[31:2]};
    assign w_wr_idx   = io_wr_addr[ADDR_W+1:2];

    // Byte-offset bits of the load address carry no information.
    assign w_unused_wr_lsb = ^io_wr_addr[1:0];

    assign w_wr_in_range = (w_wr_word < c_depth_words);

    // Fault decode on the request address; misalignment wins over range.
    always_comb begin
        w_req_fault = c_fault_ok;
        if (io_req_addr[1:0] != 2'b00) begin
            w_req_fault = c_fault_misal;
        end else if (w_req_word >= c_depth_words) begin
            w_req_fault = c_fault_range;
        end
    end

    // Entries already committed downstream: buffered plus the one in s1.
    // Ready looks only at registers and flush, never at io_resp_ready, so
    // there is no combinational path from the consumer back to the producer.
    assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
    assign w_req_ready  = !reset && !io_flush && (w_occupancy < c_resp_depth);
    assign w_accept     = io_req_valid && w_req_ready;

    assign w_resp_valid = !reset && (r_count != '0);
    assign w_push       = r_s1_valid;
    assign w_pop        = w_resp_valid && io_resp_ready;
    assign w_clear      = reset || io_flush;

    // Faulting fetches substitute the NOP so the consumer never executes junk.
    assign w_push_inst  = (r_s1_fault != c_fault_ok) ? NOP_INST : r_s1_rdata;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Program-load write; out-of-range words are dropped. Not reset.
    always_ff @(posedge clock) begin
        if (io_wr_en && w_wr_in_range) begin
            r_mem[w_wr_idx] <= io_wr_data;
        end
    end

    // Synchronous store read and capture of request info into s1 (read-first
    // against a same-cycle load write because both use the pre-edge array).
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_s1_rdata <= r_mem[w_req_idx];
            r_s1_addr  <= io_req_addr;
            r_s1_fault <= w_req_fault;
        end
    end

    // s1 occupancy; reset and flush both drop the in-flight fetch.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    // FIFO payload write at the tail; data registers need no reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr]  <= w_push_inst;
            r_fifo_addr[r_wr_ptr]  <= r_s1_addr;
            r_fifo_fault[r_wr_ptr] <= r_s1_fault;
        end
    end

    // FIFO pointers and count; wrap modulo RESP_DEPTH falls out of PTR_W.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign io_req_ready  = w_req_ready;
    assign io_resp_valid = w_resp_valid;
    assign io_resp_inst  = r_fifo_inst[r_rd_ptr];
    assign io_resp_addr  = r_fifo_addr[r_rd_ptr];
    assign io_resp_fault = r_fifo_fault[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_responder
//  Purpose  : Self-checking bench for imem_responder. A transaction-level
//             model (queue of pending responses with their earliest delivery
//             cycle plus a shadow store) is compared against the DUT every
//             cycle; a vector table and hand-written sequences add explicit
//             expectations for the corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam int          RESP_DEPTH  = 4;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [31:0] io_req_addr;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [31:0] io_resp_inst;
    logic [31:0] io_resp_addr;
    logic [1:0]  io_resp_fault;
    logic        io_flush;
    logic        io_wr_en;
    logic [31:0] io_wr_addr;
    logic [31:0] io_wr_data;

    always #5 clock = ~clock;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .RESP_DEPTH  (RESP_DEPTH),
        .NOP_INST    (NOP_INST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_addr   (io_req_addr),
        .io_resp_valid (io_resp_valid),
        .io_resp_ready (io_resp_ready),
        .io_resp_inst  (io_resp_inst),
        .io_resp_addr  (io_resp_addr),
        .io_resp_fault (io_resp_fault),
        .io_flush      (io_flush),
        .io_wr_en      (io_wr_en),
        .io_wr_addr    (io_wr_addr),
        .io_wr_data    (io_wr_data)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [1:0]  fault;
        int          avail;
    } resp_t;

    resp_t       model_q[$];
    logic [31:0] model_mem [DEPTH_WORDS];
    int          cyc;
    int          n_vec;
    int          n_bad;

    // Values sampled from the DUT during the most recent cycle.
    logic        s_ready;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_addr;
    logic [1:0]  s_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_fault(input logic [31:0] a);
        if ((a % 4) != 0) return 2'd1;
        if ((a / 4) >= DEPTH_WORDS) return 2'd2;
        return 2'd0;
    endfunction

    // One clock: sample and compare at the falling edge, advance the model to
    // the rising edge, return 1 time unit after it so the caller can drive.
    task automatic cycle();
        logic  exp_ready;
        logic  exp_valid;
        resp_t r;
        @(negedge clock);
        s_ready = io_req_ready;
        s_valid = io_resp_valid;
        s_inst  = io_resp_inst;
        s_addr  = io_resp_addr;
        s_fault = io_resp_fault;
        exp_ready = !reset && !io_flush && (model_q.size() < RESP_DEPTH);
        exp_valid = !reset && (model_q.size() > 0) && (model_q[0].avail <= cyc);
        check("req_ready", {31'b0, s_ready}, {31'b0, exp_ready});
        check("resp_valid", {31'b0, s_valid}, {31'b0, exp_valid});
        if (exp_valid && s_valid) begin
            check("resp_inst", s_inst, model_q[0].inst);
            check("resp_addr", s_addr, model_q[0].addr);
            check("resp_fault", {30'b0, s_fault}, {30'b0, model_q[0].fault});
        end
        if (reset || io_flush) begin
            model_q.delete();
        end else begin
            if (exp_valid && io_resp_ready) void'(model_q.pop_front());
            if (io_req_valid && exp_ready) begin
                r.addr  = io_req_addr;
                r.fault = exp_fault(io_req_addr);
                // word index = addr / 4; a fault-free address is below DEPTH_WORDS
                r.inst  = (r.fault == 2'd0) ? model_mem[io_req_addr[11:2]] : NOP_INST;
                r.avail = cyc + 2;
                model_q.push_back(r);
            end
        end
        // Store update after the read above: same-cycle fetch sees old data.
        if (io_wr_en && ((io_wr_addr / 4) < DEPTH_WORDS)) model_mem[io_wr_addr[11:2]] = io_wr_data;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_req_valid  = 1'b0;
        io_req_addr   = 32'h0;
        io_resp_ready = 1'b0;
        io_flush      = 1'b0;
        io_wr_en      = 1'b0;
        io_wr_addr    = 32'h0;
        io_wr_data    = 32'h0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        io_wr_en   = 1'b1;
        io_wr_addr = a;
        io_wr_data = d;
        cycle();
        io_wr_en   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Vector table: single fetches and their required response
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [1:0]  fault;
    } vec_t;

    vec_t tbl[8];

    int          n_acc;
    int          n_resp;
    int          first_i;
    int          last_i;
    int          got;
    logic [31:0] cap_inst [8];
    logic [1:0]  cap_fault [8];
    logic [31:0] a;

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h1000_0000, 2'd0};
        tbl[1] = '{32'h0000_001C, 32'h1000_0007, 2'd0};
        tbl[2] = '{32'h0000_0002, NOP_INST,      2'd1};
        tbl[3] = '{32'h0000_1000, NOP_INST,      2'd2};
        tbl[4] = '{32'h0000_1001, NOP_INST,      2'd1};
        tbl[5] = '{32'h0000_0FFC, 32'hCAFE_F00D, 2'd0};
        tbl[6] = '{32'hFFFF_FFFC, NOP_INST,      2'd2};
        tbl[7] = '{32'h0000_000C, 32'h1000_0003, 2'd0};

        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;

        // Fill the whole store so every in-range fetch has a known value.
        for (int i = 0; i < DEPTH_WORDS; i++) load_word(32'(i) << 2, $urandom);

        // --- back-to-back stream of 8 fetches -------------------------------
        for (int i = 0; i < 8; i++) load_word(32'(i) << 2, 32'h1000_0000 + 32'(i));
        load_word(32'h0000_0040, 32'h1600_0016);
        load_word(32'h0000_0FFC, 32'hCAFE_F00D);
        idle_inputs();
        io_resp_ready = 1'b1;
        n_acc = 0; n_resp = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 12; i++) begin
            io_req_valid = (i < 8);
            io_req_addr  = 32'(i) << 2;
            cycle();
            if (i < 8 && s_ready) n_acc++;
            if (s_valid) begin
                check("t1_inst", s_inst, 32'h1000_0000 + 32'(n_resp));
                if (first_i < 0) first_i = i;
                last_i = i;
                n_resp++;
            end
        end
        check("t1_accepts", n_acc, 8);
        check("t1_resp_count", n_resp, 8);
        check("t1_first_latency", first_i, 2);
        check("t1_consecutive", last_i - first_i, 7);

        // --- vector table: isolated fetches ---------------------------------
        for (int k = 0; k < 8; k++) begin
            idle_inputs();
            io_resp_ready = 1'b1;
            io_req_valid  = 1'b1;
            io_req_addr   = tbl[k].addr;
            cycle();
            io_req_valid  = 1'b0;
            got = 0;
            for (int j = 0; j < 6; j++) begin
                cycle();
                if (s_valid && got == 0) begin
                    check("tbl_inst", s_inst, tbl[k].inst);
                    check("tbl_addr", s_addr, tbl[k].addr);
                    check("tbl_fault", {30'b0, s_fault}, {30'b0, tbl[k].fault});
                    got = 1;
                end
            end
            check("tbl_response_seen", got, 1);
        end

        // --- two faulting fetches back-to-back, delivered in order ----------
        idle_inputs();
        io_resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 8; i++) begin
            io_req_valid = (i < 2);
            io_req_addr  = (i == 0) ? 32'h0000_0002 : 32'h0000_1000;
            cycle();
            if (s_valid && n_resp < 8) begin
                cap_inst[n_resp]  = s_inst;
                cap_fault[n_resp] = s_fault;
                n_resp++;
            end
        end
        check("t2_resp_count", n_resp, 2);
        check("t2_first_fault", {30'b0, cap_fault[0]}, 32'd1);
        check("t2_first_inst", cap_inst[0], NOP_INST);
        check("t2_second_fault", {30'b0, cap_fault[1]}, 32'd2);
        check("t2_second_inst", cap_inst[1], NOP_INST);

        // --- backpressure: FIFO fills, head holds, drains in order ----------
        idle_inputs();
        io_req_valid = 1'b1;
        io_req_addr  = 32'h0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_ready) begin
                n_acc++;
                io_req_addr = io_req_addr + 32'd4;
            end
            if (i == 6) cap_inst[0] = s_inst;
            if (i == 7) check("t3_head_stable", s_inst, cap_inst[0]);
        end
        check("t3_accepts", n_acc, 4);
        check("t3_ready_when_full", {31'b0, s_ready}, 32'd0);
        io_req_valid  = 1'b0;
        io_resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i == 1) check("t3_ready_after_pop", {31'b0, s_ready}, 32'd1);
            if (s_valid) begin
                check("t3_inst", s_inst, 32'h1000_0000 + 32'(n_resp));
                n_resp++;
            end
        end
        check("t3_resp_count", n_resp, 4);

        // --- flush with three buffered entries ------------------------------
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            io_req_valid = (i < 3);
            io_req_addr  = 32'(i) << 2;
            cycle();
        end
        io_flush     = 1'b1;
        io_req_valid = 1'b1;
        io_req_addr  = 32'h0000_0040;
        cycle();
        check("t4_ready_in_flush", {31'b0, s_ready}, 32'd0);
        io_flush     = 1'b0;
        io_req_valid = 1'b0;
        cycle();
        check("t4_valid_after_flush", {31'b0, s_valid}, 32'd0);
        io_resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 7; i++) begin
            io_req_valid = (i == 0);
            cycle();
            if (s_valid) begin
                check("t4_inst", s_inst, 32'h1600_0016);
                check("t4_addr", s_addr, 32'h0000_0040);
                n_resp++;
            end
        end
        check("t4_resp_count", n_resp, 1);

        // --- load write colliding with a fetch of the same word -------------
        idle_inputs();
        io_resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            io_wr_en     = (i == 0);
            io_wr_addr   = 32'h0000_0008;
            io_wr_data   = 32'hDEAD_BEEF;
            io_req_valid = (i < 2);
            io_req_addr  = 32'h0000_0008;
            cycle();
            if (s_valid && n_resp < 8) begin
                cap_inst[n_resp] = s_inst;
                n_resp++;
            end
        end
        check("t5_resp_count", n_resp, 2);
        check("t5_read_first", cap_inst[0], 32'h1000_0002);
        check("t5_refetch", cap_inst[1], 32'hDEAD_BEEF);
        idle_inputs();
        load_word(32'h0000_2000, 32'h55AA_55AA);
        io_resp_ready = 1'b1;
        n_resp = 0;
        for (int i = 0; i < 11; i++) begin
            io_req_valid = (i < 8);
            io_req_addr  = 32'(i) << 2;
            cycle();
            if (s_valid) begin
                check("t5_oor_write_dropped", s_inst,
                      (n_resp == 2) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(n_resp));
                n_resp++;
            end
        end
        check("t5_oor_resp_count", n_resp, 8);

        // --- reset with two responses buffered ------------------------------
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            io_req_valid = (i < 2);
            io_req_addr  = 32'(i) << 2;
            cycle();
        end
        reset = 1'b1;
        cycle();
        check("t6_valid_in_reset", {31'b0, s_valid}, 32'd0);
        check("t6_ready_in_reset", {31'b0, s_ready}, 32'd0);
        reset = 1'b0;
        io_resp_ready = 1'b1;
        cycle();
        check("t6_ready_after_reset", {31'b0, s_ready}, 32'd1);
        n_resp = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_valid) n_resp++;
        end
        check("t6_no_stale", n_resp, 0);

        // --- randomized traffic against the model ---------------------------
        for (int i = 0; i < 3000; i++) begin
            idle_inputs();
            reset         = ($urandom_range(0, 249) == 0);
            io_flush      = ($urandom_range(0, 29) == 0);
            io_resp_ready = ($urandom_range(0, 3) != 0);
            io_req_valid  = ($urandom_range(0, 3) != 0);
            a = 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
            case ($urandom_range(0, 9))
                0:       a = a | 32'($urandom_range(1, 3));
                1:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                default: a = a;
            endcase
            io_req_addr = a;
            if (!reset && $urandom_range(0, 7) == 0) begin
                io_wr_en   = 1'b1;
                io_wr_addr = ($urandom_range(0, 5) == 0) ? ($urandom | 32'h0000_1000)
                                                         : (32'($urandom_range(0, DEPTH_WORDS - 1)) << 2)
                                                           | 32'($urandom_range(0, 3));
                io_wr_data = $urandom;
            end
            cycle();
        end
        reset = 1'b0;
        idle_inputs();
        io_resp_ready = 1'b1;
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
